// File: rtl/bus_master_port.sv
// Per-master bus front end: turns one local command into a single bus tenure
// (request, grant, beat-by-beat burst, release) and returns one response per beat.
module bus_master_port #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              bus_clk,
    input  logic              bus_rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              m_reqn,
    input  logic              m_grntn,
    output logic              m_valn,
    output logic              m_wrn,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              bus_readyn,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t             state_q, state_nxt;
    logic               wr_q, wr_nxt;
    logic [LEN_W-1:0]   len_q, len_nxt;
    logic [LEN_W-1:0]   beat_q, beat_nxt;
    logic [LEN_W:0]     wd_cnt_q, wd_cnt_nxt;
    logic [TMO_W-1:0]   tmo_q, tmo_nxt;
    logic               wbuf_full_q, wbuf_full_nxt;

    logic               cmd_ready_nxt, m_reqn_nxt, m_valn_nxt, m_wrn_nxt;
    logic [ADDR_W-1:0]  m_addr_nxt;
    logic [DATA_W-1:0]  m_wdata_nxt, rsp_rdata_nxt;
    logic               rsp_valid_nxt, rsp_last_nxt, rsp_err_nxt;

    logic               beat_done, last_done, tmo_hit, abort, wd_fire;

    // Completion wins over grant loss when both are seen on the same edge.
    assign beat_done = (state_q == XFER) && !m_valn && !bus_readyn;
    assign last_done = beat_done && (beat_q == len_q);
    assign tmo_hit   = !m_valn && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign abort     = (state_q == XFER) && !beat_done && (m_grntn || tmo_hit);

    assign wd_ready  = ((state_q == REQ) || (state_q == XFER)) && wr_q &&
                       (wd_cnt_q <= {1'b0, len_q}) &&
                       (!wbuf_full_q || beat_done) && !abort;
    assign wd_fire   = wd_valid && wd_ready;

    always_comb begin
        state_nxt     = state_q;
        wr_nxt        = wr_q;
        len_nxt       = len_q;
        beat_nxt      = beat_q;
        wd_cnt_nxt    = wd_cnt_q;
        tmo_nxt       = tmo_q;
        wbuf_full_nxt = wbuf_full_q;
        m_reqn_nxt    = m_reqn;
        m_valn_nxt    = m_valn;
        m_wrn_nxt     = m_wrn;
        m_addr_nxt    = m_addr;
        m_wdata_nxt   = m_wdata;
        rsp_valid_nxt = 1'b0;
        rsp_last_nxt  = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = rsp_rdata;

        if (wd_fire) begin
            m_wdata_nxt = wd_data;
            wd_cnt_nxt  = wd_cnt_q + (LEN_W + 1)'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    wr_nxt        = cmd_write;
                    len_nxt       = cmd_len;
                    beat_nxt      = '0;
                    wd_cnt_nxt    = '0;
                    tmo_nxt       = '0;
                    wbuf_full_nxt = 1'b0;
                    m_addr_nxt    = cmd_addr;
                    m_wrn_nxt     = !cmd_write;
                    m_reqn_nxt    = 1'b0;
                    state_nxt     = REQ;
                end
            end
            REQ: begin
                wbuf_full_nxt = wbuf_full_q || wd_fire;
                if (!m_grntn) begin
                    m_valn_nxt = wr_q && !wbuf_full_nxt;
                    state_nxt  = XFER;
                end
            end
            XFER: begin
                wbuf_full_nxt = wd_fire || (wbuf_full_q && !beat_done);
                if (beat_done) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = wr_q ? '0 : bus_rdata;
                    beat_nxt      = beat_q + LEN_W'(1);
                    m_addr_nxt    = m_addr + ADDR_INC;
                    tmo_nxt       = '0;
                    if (last_done) begin
                        rsp_last_nxt  = 1'b1;
                        m_valn_nxt    = 1'b1;
                        m_reqn_nxt    = 1'b1;
                        wbuf_full_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end else begin
                        m_valn_nxt = wr_q && !wbuf_full_nxt;
                    end
                end else if (abort) begin
                    // Timeout or lost grant: drop the rest of the burst and any held data.
                    rsp_valid_nxt = 1'b1;
                    rsp_last_nxt  = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                    m_valn_nxt    = 1'b1;
                    m_reqn_nxt    = 1'b1;
                    wbuf_full_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else begin
                    if (!m_valn) tmo_nxt = tmo_q + TMO_W'(1);
                    m_valn_nxt = wr_q && !wbuf_full_nxt;
                end
            end
            default: state_nxt = IDLE;
        endcase

        cmd_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge bus_clk or negedge bus_rstn) begin
        if (!bus_rstn) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            len_q       <= '0;
            beat_q      <= '0;
            wd_cnt_q    <= '0;
            tmo_q       <= '0;
            wbuf_full_q <= 1'b0;
            cmd_ready   <= 1'b0;
            m_reqn      <= 1'b1;
            m_valn      <= 1'b1;
            m_wrn       <= 1'b1;
            m_addr      <= '0;
            m_wdata     <= '0;
            rsp_valid   <= 1'b0;
            rsp_last    <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state_q     <= state_nxt;
            wr_q        <= wr_nxt;
            len_q       <= len_nxt;
            beat_q      <= beat_nxt;
            wd_cnt_q    <= wd_cnt_nxt;
            tmo_q       <= tmo_nxt;
            wbuf_full_q <= wbuf_full_nxt;
            cmd_ready   <= cmd_ready_nxt;
            m_reqn      <= m_reqn_nxt;
            m_valn      <= m_valn_nxt;
            m_wrn       <= m_wrn_nxt;
            m_addr      <= m_addr_nxt;
            m_wdata     <= m_wdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_last    <= rsp_last_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
        end
    end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Per-master front end that sits directly upstream of the bus arbiter. It converts a local command stream into one bus tenure, then performs the burst and returns responses.
- Tenure sequence: drives active-low mN_reqn, waits for mN_grntn, runs the burst beat by beat against the shared bus (active-low valid/ready), then releases the request.
- One instance per master (m0..m3). Its m_reqn/m_grntn pins connect to the arbiter's mX_reqn/mX_grntn.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; address increment per beat = DATA_W/8.
- LEN_W, 4, width of cmd_len; burst = cmd_len+1 beats (1..16).
- TIMEOUT_CYC, 64, maximum cycles a presented beat may wait for bus_readyn before the burst is aborted.

Ports:
- bus_clk  in  1  clock.
- bus_rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  beats minus one.
- wd_valid  in  1  write data beat offered.
- wd_ready  out  1  write data beat accepted.
- wd_data  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse per completed or aborted beat.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_last  out  1  final response of the burst.
- rsp_err  out  1  timeout abort.
- m_reqn  out  1  bus request to arbiter, active-low.
- m_grntn  in  1  grant from arbiter, active-low.
- m_valn  out  1  beat valid on bus, active-low.
- m_wrn  out  1  0 = write, 1 = read.
- m_addr  out  ADDR_W  beat address.
- m_wdata  out  DATA_W  beat write data.
- bus_readyn  in  1  slave completes beat, active-low.
- bus_rdata  in  DATA_W  slave read data.

Behaviour:
- Reset values (async, bus_rstn low): state IDLE; m_reqn=1; m_valn=1; m_wrn=1; m_addr=0; m_wdata=0; cmd_ready=0 during reset, 1 in IDLE after reset; wd_ready=0; rsp_valid=0; rsp_last=0; rsp_err=0; rsp_rdata=0; all counters 0.
- All bus-side outputs are registered.
- States: IDLE, REQ, XFER.
- IDLE:
  - cmd_ready=1.
  - On accept: latch write/len; load m_addr=cmd_addr and m_wrn=~cmd_write; m_reqn<=0; go REQ.
- REQ:
  - Waits for m_grntn==0 while m_reqn==0.
  - A grant present in IDLE (m_grntn low with m_reqn high, e.g. m0 after arbiter reset) is ignored.
  - On sampled grant, go XFER. No grant timeout.
- XFER, beat presentation:
  - m_valn=0 iff (read) or (write and wbuf_full).
  - A write beat whose data is not yet held keeps m_valn=1 (master wait state).
- XFER, beat completion:
  - A beat completes at the clock edge where m_valn==0 and bus_readyn==0.
  - Next cycle: rsp_valid=1 for exactly one cycle; rsp_rdata=bus_rdata for reads, 0 for writes; beat counter increments; m_addr += DATA_W/8, wrapping modulo 2^ADDR_W.
- Write data buffer:
  - One-entry buffer; m_wdata is the holding register.
  - wd_ready=1 in REQ/XFER of a write burst when the buffer is empty or its beat completes this edge.
  - Beats beyond cmd_len+1 are not accepted.
- Last beat:
  - rsp_last=1 with its rsp_valid.
  - m_valn<=1, m_reqn<=1, go IDLE.
  - m_reqn therefore stays high at least 1 cycle (the IDLE cycle) before the next request, letting the arbiter rotate.
  - Back-to-back commands: next cmd_ready high the cycle after the last beat completes.
- Timeout:
  - Counter runs while m_valn==0 and clears on each completion.
  - On reaching TIMEOUT_CYC cycles without bus_readyn: rsp_valid=1, rsp_err=1, rsp_last=1; m_valn<=1, m_reqn<=1; go IDLE.
  - Remaining beats are dropped; buffered write data is discarded.
- Grant lost while in XFER (m_grntn==1): treated as abort with rsp_err=1, rsp_last=1, same release sequence.
- m_grntn and bus_readyn sampled on the same edge: completion takes precedence over grant-loss abort.
- Reset mid-burst: immediate return to reset values; no response generated; m_reqn released asynchronously.

Test Plan:
- Single read: cmd addr=0x100, len=0, grant 2 cycles after m_reqn low, slave readyn low 1 cycle with rdata=0xDEADBEEF -> one rsp_valid with rdata 0xDEADBEEF, rsp_last=1, m_reqn high the following cycle.
- 4-beat write from 0xFFFFFFF8, wd_valid gapped every other cycle -> m_valn high during data gaps; addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; four rsp_valid, last on 4th, rsp_err=0.
- Slave never asserts readyn, TIMEOUT_CYC=64 -> after 64 cycles with m_valn low: rsp_valid=1, rsp_err=1, rsp_last=1; m_reqn=1; cmd_ready=1 next cycle.
- Instance on m0 with arbiter m0 grant active at reset and no command -> m_reqn, m_valn stay 1; no bus activity.
- Two back-to-back commands with cmd_valid held -> m_reqn high for exactly 1 cycle between tenures; second burst's responses correct.
- bus_rstn low during beat 2 of a 4-beat read -> m_reqn=1, m_valn=1 immediately; no further rsp_valid; next command after reset works normally.
